// File: rtl/board_arb_pkg.sv
// Shared types and constants for the board_mem port-1 arbiter.
//   state_t  : arbiter FSM states
//   REQ_FSM  : requester index of main_fsm (hit/miss bookkeeping)
//   REQ_SCAN : requester index of the board scanner
package board_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DATA
    } state_t;

    localparam logic REQ_FSM  = 1'b0;
    localparam logic REQ_SCAN = 1'b1;

endpackage

// File: rtl/board_port_arbiter.sv
// Two-requester arbiter for the single control-side port of one board_mem.
// Accesses are serialised as IDLE -> ACCESS -> DATA, with round-robin pick on
// contention and a bounded lock for atomic read-modify-write sequences.
//
// Ports:
//   clk, rst             control clock, asynchronous active-high reset
//   reqN_i               access request, held with qualifiers until ackN_o
//   w_nrN_i              1 = write, 0 = read
//   addrN_i, wdataN_i    cell address / write data
//   lockN_i              keep ownership after this access while reqN_i is high
//   ackN_o               one-cycle completion pulse
//   rdata_o              read result, valid with ackN_o, held until next ack
//   busy_o               FSM not in IDLE
//   mem_addr_o           to board_mem addr1
//   mem_data_out_o       to board_mem write_data1
//   mem_w_nr_o           to board_mem w_nr
//   mem_data_in_i        from board_mem read_data1
module board_port_arbiter
    import board_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned MAX_LOCK   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  w_nr0_i,
    input  logic                  w_nr1_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    input  logic                  lock0_i,
    input  logic                  lock1_i,
    output logic                  ack0_o,
    output logic                  ack1_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_out_o,
    output logic                  mem_w_nr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_in_i
);

    localparam int unsigned       CntW     = 4;
    localparam logic [CntW-1:0]   LockLast = CntW'(MAX_LOCK - 1);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic [CntW-1:0]       lock_cnt_q, lock_cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  mem_w_nr_q, mem_w_nr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  busy_q, busy_d;

    logic                  winner;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_w_nr;
    logic                  own_req;
    logic                  own_lock;
    logic                  oth_req;
    logic                  chain;

    // Qualifier mux: in IDLE load from the fresh winner, in DATA from the
    // current owner (a chained access samples the owner's inputs in DATA).
    always_comb begin
        winner    = (req0_i && req1_i) ? ~last_owner_q : req1_i;
        sel       = (state_q == IDLE) ? winner : owner_q;
        sel_addr  = sel ? addr1_i : addr0_i;
        sel_wdata = sel ? wdata1_i : wdata0_i;
        sel_w_nr  = sel ? w_nr1_i : w_nr0_i;
        own_req   = owner_q ? req1_i : req0_i;
        own_lock  = owner_q ? lock1_i : lock0_i;
        oth_req   = owner_q ? req0_i : req1_i;
        // Give up the port on the MAX_LOCK-th chained grant if the other side waits.
        chain     = own_lock && own_req && !(oth_req && (lock_cnt_q == LockLast));
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        lock_cnt_d   = lock_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_w_nr_d   = 1'b0;
        rdata_d      = rdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    owner_d    = winner;
                    mem_addr_d = sel_addr;
                    mem_data_d = sel_wdata;
                    mem_w_nr_d = sel_w_nr;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                state_d = DATA;
            end
            DATA: begin
                rdata_d      = mem_data_in_i;
                last_owner_d = owner_q;
                if (owner_q == REQ_SCAN) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
                if (chain) begin
                    if (lock_cnt_q != LockLast) begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                    mem_addr_d = sel_addr;
                    mem_data_d = sel_wdata;
                    mem_w_nr_d = sel_w_nr;
                    state_d    = ACCESS;
                end else begin
                    lock_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Asynchronous reset drops mem_w_nr immediately so an in-flight write is
    // never committed once reset is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= REQ_FSM;
            last_owner_q <= REQ_SCAN;
            lock_cnt_q   <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_w_nr_q   <= 1'b0;
            rdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_w_nr_q   <= mem_w_nr_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0_o         = ack0_q;
    assign ack1_o         = ack1_q;
    assign rdata_o        = rdata_q;
    assign busy_o         = busy_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_out_o = mem_data_q;
    assign mem_w_nr_o     = mem_w_nr_q;

endmodule

// File: tb/tb_board_port_arbiter.sv
// Self-checking bench for board_port_arbiter with a behavioural board_mem
// (synchronous write, registered read-first output on port 1).
module tb_board_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, w_nr0, w_nr1, lock0, lock1;
    logic [7:0] addr0, addr1;
    logic [1:0] wdata0, wdata1;
    logic       ack0, ack1, busy, mem_w_nr;
    logic [1:0] rdata, mem_data_out, mem_rd;
    logic [7:0] mem_addr;

    logic [1:0] mem [256];
    logic       mem_load;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req0_i         (req0),
        .req1_i         (req1),
        .w_nr0_i        (w_nr0),
        .w_nr1_i        (w_nr1),
        .addr0_i        (addr0),
        .addr1_i        (addr1),
        .wdata0_i       (wdata0),
        .wdata1_i       (wdata1),
        .lock0_i        (lock0),
        .lock1_i        (lock1),
        .ack0_o         (ack0),
        .ack1_o         (ack1),
        .rdata_o        (rdata),
        .busy_o         (busy),
        .mem_addr_o     (mem_addr),
        .mem_data_out_o (mem_data_out),
        .mem_w_nr_o     (mem_w_nr),
        .mem_data_in_i  (mem_rd)
    );

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 2'b00;
            mem[8'h23] <= 2'b10;
            mem[8'h10] <= 2'b11;
        end else begin
            if (mem_w_nr) mem[mem_addr] <= mem_data_out;
            mem_rd <= mem[mem_addr];
        end
    end

    typedef struct {
        logic       who;
        logic       w;
        logic [7:0] addr;
        logic [1:0] wdata;
        logic       chk;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack0"}, 32'(ack0), 32'd0);
        check({tag, "_ack1"}, 32'(ack1), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_data_out"}, 32'(mem_data_out), 32'd0);
        check({tag, "_mem_w_nr"}, 32'(mem_w_nr), 32'd0);
    endtask

    // One uncontested access: ACCESS, DATA, then ack 3 cycles after request.
    task automatic do_single(input vec_t v);
        logic mine, other;
        if (v.who) begin
            req1 = 1'b1; w_nr1 = v.w; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; w_nr0 = v.w; addr0 = v.addr; wdata0 = v.wdata;
        end
        tick();
        check("single_acc_busy", 32'(busy), 32'd1);
        check("single_acc_addr", 32'(mem_addr), 32'(v.addr));
        check("single_acc_wnr", 32'(mem_w_nr), 32'(v.w));
        if (v.w) check("single_acc_wdata", 32'(mem_data_out), 32'(v.wdata));
        tick();
        check("single_data_wnr", 32'(mem_w_nr), 32'd0);
        check("single_data_noack", 32'(ack0 | ack1), 32'd0);
        tick();
        mine  = v.who ? ack1 : ack0;
        other = v.who ? ack0 : ack1;
        check("single_ack", 32'(mine), 32'd1);
        check("single_other_ack", 32'(other), 32'd0);
        if (v.chk) check("single_rdata", 32'(rdata), 32'(v.exp));
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("single_ack_pulse", 32'(ack0 | ack1), 32'd0);
        check("single_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_t[6];
        int n;
        logic exp_w[6];

        vecs[0] = '{who: 1'b0, w: 1'b0, addr: 8'h23, wdata: 2'b00, chk: 1'b1, exp: 2'b10};
        vecs[1] = '{who: 1'b1, w: 1'b1, addr: 8'h5B, wdata: 2'b11, chk: 1'b0, exp: 2'b00};
        vecs[2] = '{who: 1'b0, w: 1'b0, addr: 8'h5B, wdata: 2'b00, chk: 1'b1, exp: 2'b11};
        vecs[3] = '{who: 1'b1, w: 1'b1, addr: 8'h10, wdata: 2'b10, chk: 1'b0, exp: 2'b00};
        vecs[4] = '{who: 1'b1, w: 1'b0, addr: 8'h10, wdata: 2'b00, chk: 1'b1, exp: 2'b10};
        vecs[5] = '{who: 1'b0, w: 1'b0, addr: 8'h23, wdata: 2'b00, chk: 1'b1, exp: 2'b10};

        rst = 1'b1; mem_load = 1'b1;
        req0 = 1'b0; req1 = 1'b0; w_nr0 = 1'b0; w_nr1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        check_zero("reset");
        mem_load = 1'b0;
        rst = 1'b0;

        // Contention from reset: 0 wins first, then strict alternation.
        exp_t = '{3, 6, 9, 12, 0, 0};
        exp_w = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        req0 = 1'b1; addr0 = 8'h23; req1 = 1'b1; addr1 = 8'h5B;
        n = 0;
        for (int t = 1; t <= 20 && n < 4; t++) begin
            tick();
            check("contend_both_acks", 32'(ack0 & ack1), 32'd0);
            if (ack0 | ack1) begin
                check("contend_time", 32'(t), 32'(exp_t[n]));
                check("contend_owner", 32'(ack1), 32'(exp_w[n]));
                n++;
            end
        end
        check("contend_count", 32'(n), 32'd4);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("contend_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) do_single(vecs[i]);

        // Locked RMW on 8'h10 while requester 1 waits.
        req0 = 1'b1; lock0 = 1'b1; w_nr0 = 1'b0; addr0 = 8'h10; wdata0 = 2'b00;
        tick();
        check("rmw_rd_addr", 32'(mem_addr), 32'h10);
        check("rmw_rd_wnr", 32'(mem_w_nr), 32'd0);
        req1 = 1'b1; w_nr1 = 1'b0; addr1 = 8'h23;
        tick();
        w_nr0 = 1'b1; wdata0 = 2'b01;
        tick();
        check("rmw_ack0_rd", 32'(ack0), 32'd1);
        check("rmw_ack1_early", 32'(ack1), 32'd0);
        check("rmw_rdata", 32'(rdata), 32'h2);
        check("rmw_wr_wnr", 32'(mem_w_nr), 32'd1);
        check("rmw_wr_addr", 32'(mem_addr), 32'h10);
        check("rmw_wr_data", 32'(mem_data_out), 32'h1);
        lock0 = 1'b0;
        tick();
        check("rmw_wnr_one_cycle", 32'(mem_w_nr), 32'd0);
        check("rmw_gap_acks", 32'(ack0 | ack1), 32'd0);
        tick();
        check("rmw_ack0_wr", 32'(ack0), 32'd1);
        check("rmw_ack1_still_wait", 32'(ack1), 32'd0);
        req0 = 1'b0; w_nr0 = 1'b0;
        tick();
        check("rmw_grant1_addr", 32'(mem_addr), 32'h23);
        tick();
        tick();
        check("rmw_ack1", 32'(ack1), 32'd1);
        check("rmw_ack1_rdata", 32'(rdata), 32'h2);
        req1 = 1'b0;
        tick();
        do_single('{who: 1'b0, w: 1'b0, addr: 8'h10, wdata: 2'b00, chk: 1'b1, exp: 2'b01});

        // Lock bound: 4 chained grants, then requester 1, then requester 0 again.
        exp_t = '{3, 5, 7, 9, 12, 15};
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        req0 = 1'b1; lock0 = 1'b1; w_nr0 = 1'b0; addr0 = 8'h23;
        n = 0;
        for (int t = 1; t <= 30 && n < 6; t++) begin
            tick();
            if (t == 1) begin
                req1 = 1'b1; w_nr1 = 1'b0; addr1 = 8'h5B;
            end
            check("lock_both_acks", 32'(ack0 & ack1), 32'd0);
            if (ack0 | ack1) begin
                check("lock_time", 32'(t), 32'(exp_t[n]));
                check("lock_owner", 32'(ack1), 32'(exp_w[n]));
                n++;
            end
        end
        check("lock_count", 32'(n), 32'd6);
        req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0;
        for (int t = 0; t < 10 && busy; t++) tick();
        check("lock_drain_idle", 32'(busy), 32'd0);
        tick();

        // Reset during a write to 8'h23: write must not land.
        req1 = 1'b1; w_nr1 = 1'b1; addr1 = 8'h23; wdata1 = 2'b01;
        tick();
        check("rstw_wnr_before", 32'(mem_w_nr), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_zero("rstw");
        req1 = 1'b0; w_nr1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        req0 = 1'b1; w_nr0 = 1'b0; addr0 = 8'h23;
        req1 = 1'b1; w_nr1 = 1'b0; addr1 = 8'h5B;
        tick();
        tick();
        tick();
        check("rstw_first_grant0", 32'(ack0), 32'd1);
        check("rstw_no_ack1", 32'(ack1), 32'd0);
        check("rstw_cell_kept", 32'(rdata), 32'h2);
        req0 = 1'b0; req1 = 1'b0;
        for (int t = 0; t < 10 && busy; t++) tick();
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
